// File: rtl/slow_clk_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slow_clk_monitor
// Brief    : Brings the divided slow clock into the fast clk domain. Emits a
//            one-cycle step enable per slow rising edge, measures the slow
//            period in clk cycles and flags a stalled divider.
// Revision : 1.0 - initial release
// ============================================================================
module slow_clk_monitor #(
  parameter int TIMEOUT = 25000002,  // clk cycles without a rise before stall (>= 4)
  parameter int CNT_W   = 32         // cycle counter / period width
) (
  input  logic             clk,
  input  logic             reset,         // asynchronous, active-low
  input  logic             slow_in,       // asynchronous slow clock
  input  logic             halt,          // synchronous core halt
  output logic             step,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_stall_at = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALL   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_rise;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_step;
  logic             r_stalled;
  logic [15:0]      r_edge_count;

  logic             w_fire;      // emit a step pulse this edge
  logic             w_load;      // capture a new period measurement this edge

  // Two-flop synchroniser plus history flop; runs even during halt so a
  // level that rose while halted does not look like a fresh edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= slow_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  // Cycles since the last sampled rise; held at zero while halted, saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (halt || w_rise) begin
      r_cnt <= '0;
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and pulse decisions; halt overrides everything, and a rise
  // takes priority over the timeout in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_load       = 1'b0;
    if (halt) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_next = ST_MEASURE;
            w_fire       = 1'b1;
          end else if (r_cnt == c_stall_at) begin
            w_state_next = ST_STALL;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            w_fire = 1'b1;
            w_load = 1'b1;
          end else if (r_cnt == c_stall_at) begin
            w_state_next = ST_STALL;
          end
        end
        ST_STALL: begin
          // The interval that ends here spans a stall, so it is not measured.
          if (w_rise) begin
            w_state_next = ST_MEASURE;
            w_fire       = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs: step pulse, pulse counter and stall flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step       <= 1'b0;
      r_edge_count <= 16'd0;
      r_stalled    <= 1'b0;
    end else begin
      r_step    <= w_fire;
      r_stalled <= (w_state_next == ST_STALL);
      if (w_fire) begin
        r_edge_count <= r_edge_count + 16'd1;
      end
    end
  end

  // Period capture; a saturated counter reports all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else if (w_load) begin
      r_period       <= (r_cnt == c_cnt_max) ? c_cnt_max : (r_cnt + c_one);
      r_period_valid <= 1'b1;
    end
  end

  assign step         = r_step;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign stalled      = r_stalled;
  assign edge_count   = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_slow_clk_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_slow_clk_monitor
// Brief    : Directed, table-driven bench for slow_clk_monitor (TIMEOUT=40).
//            Each vector is one slow period: high/low durations, halt level
//            and the hand-computed outputs expected at the end of the period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slow_clk_monitor;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 32;

  logic             clk;
  logic             reset;
  logic             slow_in;
  logic             halt;
  logic             step;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stalled;
  logic [15:0]      edge_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          hi;           // clk cycles slow_in high
    int          lo;           // clk cycles slow_in low
    bit          hlt;          // halt level for the whole vector
    int          exp_steps;    // step pulses expected
    int          exp_step_at;  // sample index of the pulse (-1: none)
    int          exp_stall_at; // sample index of stalled 0->1 (-1: none)
    logic [31:0] exp_period;
    bit          exp_pv;
    bit          exp_stalled;  // level at the end of the vector
    logic [15:0] exp_ec;
  } vec_t;

  vec_t vecs [12];

  slow_clk_monitor #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .slow_in      (slow_in),
    .halt         (halt),
    .step         (step),
    .period       (period),
    .period_valid (period_valid),
    .stalled      (stalled),
    .edge_count   (edge_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clk edge; samples are taken 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_step"},   longint'(step),         0);
    check({tag, "_period"}, longint'(period),       0);
    check({tag, "_pv"},     longint'(period_valid), 0);
    check({tag, "_stall"},  longint'(stalled),      0);
    check({tag, "_ec"},     longint'(edge_count),   0);
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int nsteps;
    int step_at;
    int stall_at;
    bit prev_step;
    bit prev_stalled;
    bit dbl;
    nsteps       = 0;
    step_at      = -1;
    stall_at     = -1;
    prev_step    = 1'b0;
    prev_stalled = stalled;
    dbl          = 1'b0;
    halt         = v.hlt;
    for (int j = 0; j < v.hi + v.lo; j++) begin
      slow_in = (j < v.hi);
      tick();
      if (step) begin
        nsteps++;
        if (step_at < 0) step_at = j;
        if (prev_step) dbl = 1'b1;
      end
      prev_step = step;
      if (stalled && !prev_stalled && stall_at < 0) stall_at = j;
      prev_stalled = stalled;
    end
    check({tag, "_nsteps"},   nsteps,                   v.exp_steps);
    check({tag, "_step_at"},  step_at,                  v.exp_step_at);
    check({tag, "_dbl_step"}, longint'(dbl),            0);
    check({tag, "_stall_at"}, stall_at,                 v.exp_stall_at);
    check({tag, "_period"},   longint'(period),         longint'(v.exp_period));
    check({tag, "_pv"},       longint'(period_valid),   longint'(v.exp_pv));
    check({tag, "_stalled"},  longint'(stalled),        longint'(v.exp_stalled));
    check({tag, "_ec"},       longint'(edge_count),     longint'(v.exp_ec));
  endtask

  initial begin
    vec_t w;
    reset   = 1'b0;
    slow_in = 1'b0;
    halt    = 1'b0;

    //          hi  lo  hlt n  at  stall per pv st ec
    vecs[0]  = '{10, 10, 0, 1,  2, -1,   0, 0, 0, 16'd1};  // first edge: no period
    vecs[1]  = '{10, 10, 0, 1,  2, -1,  20, 1, 0, 16'd2};
    vecs[2]  = '{10, 10, 0, 1,  2, -1,  20, 1, 0, 16'd3};
    vecs[3]  = '{10, 60, 0, 1,  2, 42,  20, 1, 1, 16'd4};  // stall 40 after rise
    vecs[4]  = '{10, 10, 0, 1,  2, -1,  20, 1, 0, 16'd5};  // recovery, no update
    vecs[5]  = '{10, 10, 0, 1,  2, -1,  20, 1, 0, 16'd6};
    vecs[6]  = '{10, 10, 1, 0, -1, -1,  20, 1, 0, 16'd6};  // halted
    vecs[7]  = '{10, 10, 1, 0, -1, -1,  20, 1, 0, 16'd6};
    vecs[8]  = '{10, 10, 1, 0, -1, -1,  20, 1, 0, 16'd6};
    vecs[9]  = '{10, 10, 0, 1,  2, -1,  20, 1, 0, 16'd7};  // first edge after halt
    vecs[10] = '{10, 30, 0, 1,  2, -1,  20, 1, 0, 16'd8};  // sets up the race
    vecs[11] = '{10, 10, 0, 1,  2, -1,  40, 1, 0, 16'd9};  // rise meets TIMEOUT-1

    // Reset held while slow_in toggles: everything stays cleared.
    for (int j = 0; j < 6; j++) begin
      slow_in = j[0];
      tick();
    end
    check_all_zero("rst_hold");
    slow_in = 1'b0;
    tick();
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Counter wrap: preload near the wrap point instead of 65536 real edges.
    force dut.r_edge_count = 16'hFFFE;
    #1;
    release dut.r_edge_count;
    w = '{10, 10, 0, 1, 2, -1, 20, 1, 0, 16'hFFFF};
    apply_vec("wrap_ffff", w);
    w.exp_ec = 16'h0000;
    apply_vec("wrap_0000", w);
    w.exp_ec = 16'h0001;
    apply_vec("wrap_0001", w);

    // Asynchronous reset between clk edges clears outputs immediately.
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    check_all_zero("async_rst_edge");
    slow_in = 1'b0;
    reset   = 1'b1;

    // First edge after reset is handled as IDLE; the next one measures.
    w = '{10, 10, 0, 1, 2, -1, 0, 0, 0, 16'd1};
    apply_vec("post_rst0", w);
    w = '{10, 10, 0, 1, 2, -1, 20, 1, 0, 16'd2};
    apply_vec("post_rst1", w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
